// File: rtl/led_sweep_anim_pkg.sv
// Shared types and helpers for the LED sweep animator: FSM states, mode codes
// and the index-to-LED position mapping.
package led_anim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FILL  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_WIPE  = 2'd0;
  localparam logic [1:0] MODE_DRAIN = 2'd1;
  localparam logic [1:0] MODE_FILL  = 2'd2;

  // dir=1 walks up from led[0]; dir=0 walks down from led[n-1].
  function automatic int unsigned led_pos(input int unsigned idx,
                                          input logic        dir,
                                          input int unsigned n);
    return dir ? idx : (n - 32'd1 - idx);
  endfunction

endpackage

// File: rtl/led_sweep_anim_if.sv
// Control/status bundle between game logic and the LED sweep animator.
interface led_sweep_anim_if #(
  parameter int N_LEDS = 16
);
  logic              trigger;
  logic              dir;
  logic [1:0]        mode;
  logic              abort;
  logic [N_LEDS-1:0] led;
  logic              busy;
  logic              done;

  modport master (
    output trigger, dir, mode, abort,
    input  led, busy, done
  );

  modport slave (
    input  trigger, dir, mode, abort,
    output led, busy, done
  );
endinterface

// File: rtl/led_sweep_anim_tick_gen.sv
// Clock-enable generator: one-cycle tick every DIV enabled cycles, with a
// synchronous clear that restarts the count from zero.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);
  localparam int            CW   = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_tick = i_en & (r_cnt == LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/led_sweep_anim.sv
// LED bar sweep animator: WIPE / DRAIN / FILL sweeps, one LED per tick,
// with level abort back to an all-on idle bar.
module led_sweep_anim
  import led_anim_pkg::*;
#(
  parameter int N_LEDS     = 16,
  parameter int TICK_DIV   = 1_250_000,
  parameter int HOLD_TICKS = 8
) (
  input  logic           clk,
  input  logic           rst,
  led_sweep_anim_if.slave bus
);
  localparam int               IDX_W    = $clog2(N_LEDS);
  localparam int               HOLD_W   = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_LEDS - 1);

  state_t            r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic [HOLD_W-1:0] r_hold, w_hold_nxt;
  logic [N_LEDS-1:0] r_led, w_led_nxt;
  logic              r_done, w_done_nxt;
  logic              r_dir, w_dir_nxt;
  logic [1:0]        r_mode, w_mode_nxt;

  logic              w_busy;
  logic              w_accept;
  logic              w_tick;
  logic              w_tick_clr;
  logic              w_last;
  logic              w_hold_last;
  logic [IDX_W-1:0]  w_pos;

  assign w_busy      = (r_state != ST_IDLE);
  assign w_accept    = bus.trigger & ~bus.abort & ~w_busy;
  assign w_tick_clr  = w_accept | bus.abort;
  assign w_last      = (r_idx == IDX_LAST);
  // Written as hold+1 == HOLD_TICKS so HOLD_TICKS=0 never yields a negative bound.
  assign w_hold_last = ((32'(r_hold) + 32'd1) == 32'(HOLD_TICKS));
  assign w_pos       = IDX_W'(led_pos(32'(r_idx), r_dir, 32'(N_LEDS)));

  tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick_gen (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_clr  (w_tick_clr),
    .i_en   (w_busy),
    .o_tick (w_tick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_hold_nxt  = r_hold;
    w_led_nxt   = r_led;
    w_done_nxt  = 1'b0;
    w_dir_nxt   = r_dir;
    w_mode_nxt  = r_mode;

    if (bus.abort) begin
      w_state_nxt = ST_IDLE;
      w_idx_nxt   = '0;
      w_hold_nxt  = '0;
      w_led_nxt   = '1;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.trigger) begin
            w_dir_nxt   = bus.dir;
            w_mode_nxt  = bus.mode;
            w_idx_nxt   = '0;
            w_hold_nxt  = '0;
            w_state_nxt = (bus.mode == MODE_FILL) ? ST_FILL : ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          if (w_tick) begin
            w_led_nxt[w_pos] = 1'b0;
            if (w_last) begin
              w_idx_nxt = '0;
              if (r_mode == MODE_DRAIN) begin
                w_state_nxt = ST_IDLE;
                w_done_nxt  = 1'b1;
              end else if (HOLD_TICKS == 0) begin
                w_state_nxt = ST_FILL;
              end else begin
                w_state_nxt = ST_HOLD;
              end
            end else begin
              w_idx_nxt = r_idx + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (w_tick) begin
            if (w_hold_last) begin
              w_hold_nxt  = '0;
              w_state_nxt = ST_FILL;
            end else begin
              w_hold_nxt = r_hold + 1'b1;
            end
          end
        end
        ST_FILL: begin
          if (w_tick) begin
            w_led_nxt[w_pos] = 1'b1;
            if (w_last) begin
              w_idx_nxt   = '0;
              w_state_nxt = ST_IDLE;
              w_done_nxt  = 1'b1;
            end else begin
              w_idx_nxt = r_idx + 1'b1;
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_hold  <= '0;
      r_led   <= '1;
      r_done  <= 1'b0;
      r_dir   <= 1'b0;
      r_mode  <= MODE_WIPE;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_hold  <= w_hold_nxt;
      r_led   <= w_led_nxt;
      r_done  <= w_done_nxt;
      r_dir   <= w_dir_nxt;
      r_mode  <= w_mode_nxt;
    end
  end

  assign bus.led  = r_led;
  assign bus.busy = w_busy;
  assign bus.done = r_done;
endmodule

// File: tb/tb_led_sweep_anim.sv
// Scoreboard bench for led_sweep_anim: an 8-LED and a 5-LED instance driven
// with directed and random sweeps, checked against a per-tick pattern model.
module tb_led_sweep_anim;
  import led_anim_pkg::*;

  localparam int DIV = 4;
  localparam int N0 = 8, H0 = 2;
  localparam int N1 = 5, H1 = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  led_sweep_anim_if #(.N_LEDS(N0)) if0 ();
  led_sweep_anim_if #(.N_LEDS(N1)) if1 ();

  led_sweep_anim #(.N_LEDS(N0), .TICK_DIV(DIV), .HOLD_TICKS(H0)) dut0 (
    .clk (clk), .rst (rst), .bus (if0.slave));
  led_sweep_anim #(.N_LEDS(N1), .TICK_DIV(DIV), .HOLD_TICKS(H1)) dut1 (
    .clk (clk), .rst (rst), .bus (if1.slave));

  typedef struct {
    int         cyc;
    logic [7:0] led;
    logic       busy;
    logic       done;
  } ev_t;

  ev_t        sb0[$];
  ev_t        sb1[$];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] exp_idle [2];
  logic [7:0] prev_led [2];
  logic       prev_busy [2];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mask(input int inst);
    return (inst != 0) ? 8'h1F : 8'hFF;
  endfunction

  function automatic void push(input int inst, input int c, input logic [7:0] l,
                               input logic b, input logic d);
    ev_t e;
    e.cyc = c; e.led = l; e.busy = b; e.done = d;
    if (inst == 0) sb0.push_back(e);
    else           sb1.push_back(e);
  endfunction

  function automatic void flush(input int inst, input int a);
    ev_t tmp[$];
    if (inst == 0) begin
      foreach (sb0[i]) if (sb0[i].cyc < a) tmp.push_back(sb0[i]);
      sb0 = tmp;
    end else begin
      foreach (sb1[i]) if (sb1[i].cyc < a) tmp.push_back(sb1[i]);
      sb1 = tmp;
    end
  endfunction

  // Reference model: the bar pattern after every tick of a sweep accepted at edge k.
  function automatic int build(input int inst, input int k, input logic [1:0] m, input logic d);
    int n, h, t_tot, p;
    logic [7:0] pat, prv;
    n     = (inst != 0) ? N1 : N0;
    h     = (inst != 0) ? H1 : H0;
    t_tot = (m == 2'd1 || m == 2'd2) ? n : 2 * n + h;
    pat   = exp_idle[inst];
    push(inst, k, pat, 1'b1, 1'b0);
    for (int t = 1; t <= t_tot; t++) begin
      prv = pat;
      if (m == 2'd2) begin
        p = d ? t - 1 : n - t;
        pat[p[2:0]] = 1'b1;
      end else if (m == 2'd1 || t <= n) begin
        p = d ? t - 1 : n - t;
        pat[p[2:0]] = 1'b0;
      end else if (t > n + h) begin
        p = d ? t - n - h - 1 : n - (t - n - h);
        pat[p[2:0]] = 1'b1;
      end
      if (pat != prv || t == t_tot)
        push(inst, k + t * DIV, pat, (t != t_tot), (t == t_tot));
    end
    exp_idle[inst] = pat;
    return k + t_tot * DIV;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic mon(input int inst, input logic [7:0] l, input logic b, input logic d);
    ev_t e;
    bit  have;
    if (l != prev_led[inst] || b != prev_busy[inst] || d) begin
      have = (inst == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
      n_chk++;
      if (!have) begin
        n_fail++;
        $display("FAIL unexpected_event inst%0d: got cyc=%0d led=%h busy=%b done=%b, expected no event",
                 inst, cyc, l, b, d);
      end else begin
        if (inst == 0) e = sb0.pop_front();
        else           e = sb1.pop_front();
        if (e.cyc != cyc || e.led != l || e.busy != b || e.done != d) begin
          n_fail++;
          $display("FAIL event inst%0d: got cyc=%0d led=%h busy=%b done=%b, expected cyc=%0d led=%h busy=%b done=%b",
                   inst, cyc, l, b, d, e.cyc, e.led, e.busy, e.done);
        end
      end
    end
    prev_led[inst]  = l;
    prev_busy[inst] = b;
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      mon(0, if0.led, if0.busy, if0.done);
      mon(1, {3'b000, if1.led}, if1.busy, if1.done);
    end
  end

  task automatic drive(input int inst, input logic tr, input logic d,
                       input logic [1:0] m, input logic ab);
    if (inst == 0) begin
      if0.trigger = tr; if0.dir = d; if0.mode = m; if0.abort = ab;
    end else begin
      if1.trigger = tr; if1.dir = d; if1.mode = m; if1.abort = ab;
    end
  endtask

  // Starts at a negedge and returns at a negedge; gap=0 retriggers right after done.
  task automatic run_seq(input int inst, input logic [1:0] m, input logic d,
                         input int gap, input int abort_off, input bit noise);
    int k, e, a;
    repeat (gap) @(negedge clk);
    k = cyc + 1;
    e = build(inst, k, m, d);
    a = (abort_off > 0) ? k + ((abort_off - 1) % (e - k)) + 1 : -1;
    drive(inst, 1'b1, d, m, 1'b0);
    @(negedge clk);
    drive(inst, 1'b0, 1'b0, 2'd0, 1'b0);
    while (cyc < e) begin
      if (cyc == a - 1) begin
        drive(inst, 1'b0, d, m, 1'b1);
        flush(inst, a);
        push(inst, a, mask(inst), 1'b0, 1'b0);
        exp_idle[inst] = mask(inst);
        @(negedge clk);
        drive(inst, 1'b0, 1'b0, 2'd0, 1'b0);
        return;
      end
      drive(inst, noise && ($urandom_range(0, 3) == 0), 1'($urandom), 2'($urandom), 1'b0);
      @(negedge clk);
    end
    drive(inst, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic idle_abort(input int inst);
    int a;
    a = cyc + 1;
    drive(inst, 1'b1, 1'b1, 2'd0, 1'b1);
    if (exp_idle[inst] != mask(inst)) push(inst, a, mask(inst), 1'b0, 1'b0);
    exp_idle[inst] = mask(inst);
    @(negedge clk);
    drive(inst, 1'b0, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    chk("idle_abort_busy", {7'b0, (inst == 0) ? if0.busy : if1.busy}, 8'h00);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, e;
    drive(0, 1'b0, 1'b0, 2'd0, 1'b0);
    drive(1, 1'b0, 1'b0, 2'd0, 1'b0);
    exp_idle[0] = 8'hFF; exp_idle[1] = 8'h1F;
    prev_led[0] = 8'hFF; prev_led[1] = 8'h1F;
    prev_busy[0] = 1'b0; prev_busy[1] = 1'b0;

    repeat (3) @(posedge clk);
    #2;
    chk("reset_led0",  if0.led, 8'hFF);
    chk("reset_busy0", {7'b0, if0.busy}, 8'h00);
    chk("reset_done0", {7'b0, if0.done}, 8'h00);
    chk("reset_led1",  {3'b0, if1.led}, 8'h1F);
    chk("reset_busy1", {7'b0, if1.busy}, 8'h00);
    chk("reset_done1", {7'b0, if1.done}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_seq(0, MODE_WIPE,  1'b1, 0, 0, 1'b0);
    run_seq(0, MODE_DRAIN, 1'b0, 2, 0, 1'b0);
    run_seq(0, MODE_FILL,  1'b1, 1, 0, 1'b0);
    run_seq(0, MODE_WIPE,  1'b0, 0, 0, 1'b1);
    run_seq(0, MODE_WIPE,  1'b1, 0, 0, 1'b1);
    run_seq(0, MODE_WIPE,  1'b1, 1, 5 * DIV, 1'b0);
    idle_abort(0);
    run_seq(0, MODE_DRAIN, 1'b1, 0, 0, 1'b0);
    idle_abort(0);

    // Async reset in the middle of a FILL from an empty bar.
    run_seq(0, MODE_DRAIN, 1'b0, 1, 0, 1'b0);
    k = cyc + 1;
    e = build(0, k, MODE_FILL, 1'b1);
    drive(0, 1'b1, 1'b1, MODE_FILL, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 2'd0, 1'b0);
    repeat (3 * DIV + 1) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_led",  if0.led, 8'hFF);
    chk("async_rst_busy", {7'b0, if0.busy}, 8'h00);
    chk("async_rst_done", {7'b0, if0.done}, 8'h00);
    flush(0, 0);
    exp_idle[0] = 8'hFF;
    @(negedge clk);
    rst = 1'b0;
    push(0, cyc + 1, 8'hFF, 1'b0, 1'b0);

    run_seq(0, MODE_WIPE, 1'b0, 2, 0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      run_seq(0, 2'($urandom), 1'($urandom), $urandom_range(0, 3),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 80)) : 0,
              1'($urandom));
      if ($urandom_range(0, 7) == 0) idle_abort(0);
    end

    run_seq(1, 2'd3, 1'b1, 0, 0, 1'b0);
    run_seq(1, 2'd3, 1'b0, 0, 0, 1'b1);
    run_seq(1, MODE_DRAIN, 1'b0, 1, 0, 1'b0);
    run_seq(1, 2'd3, 1'b1, 0, 0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      run_seq(1, 2'($urandom), 1'($urandom), $urandom_range(0, 2),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : 0,
              1'($urandom));
    end

    repeat (3 * DIV) @(negedge clk);
    n_chk++;
    if (sb0.size() != 0) begin
      n_fail++;
      $display("FAIL pending_events inst0: got %0d left, expected 0", sb0.size());
    end
    n_chk++;
    if (sb1.size() != 0) begin
      n_fail++;
      $display("FAIL pending_events inst1: got %0d left, expected 0", sb1.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
